// File: rtl/imem_arbiter.sv
// rtl/imem_arbiter.sv - round-robin arbiter sharing the instruction ROM read port between CPU fetch and debug
module imem_arbiter #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_3000,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cpu_req,
    input  logic [31:0]      cpu_addr,
    output logic             cpu_gnt,
    output logic             cpu_rvalid,
    output logic [31:0]      cpu_rdata,
    output logic             cpu_err,
    input  logic             dbg_req,
    input  logic [31:0]      dbg_addr,
    output logic             dbg_gnt,
    output logic             dbg_rvalid,
    output logic [31:0]      dbg_rdata,
    output logic             dbg_err,
    output logic [11:0]      imem_addr,
    input  logic [31:0]      imem_instr,
    output logic [CNT_W-1:0] conflict_cnt
);

    // One past the last valid byte address, widened so BASE + size cannot wrap.
    localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + (33'(DEPTH_WORDS) << 2);

    logic             last_gnt_q, last_gnt_d;
    logic             cpu_rvalid_q, cpu_rvalid_d;
    logic [31:0]      cpu_rdata_q, cpu_rdata_d;
    logic             cpu_err_q, cpu_err_d;
    logic             dbg_rvalid_q, dbg_rvalid_d;
    logic [31:0]      dbg_rdata_q, dbg_rdata_d;
    logic             dbg_err_q, dbg_err_d;
    logic [CNT_W-1:0] conflict_cnt_q, conflict_cnt_d;

    logic [31:0]      sel_addr;
    logic [32:0]      sel_addr_ext;
    logic             addr_err;

    // Grant decision: single requester wins outright, contention goes to the port not served last.
    always_comb begin
        cpu_gnt = 1'b0;
        dbg_gnt = 1'b0;
        if (rst_n) begin
            if (cpu_req && dbg_req) begin
                if (last_gnt_q) begin
                    cpu_gnt = 1'b1;
                end else begin
                    dbg_gnt = 1'b1;
                end
            end else if (cpu_req) begin
                cpu_gnt = 1'b1;
            end else if (dbg_req) begin
                dbg_gnt = 1'b1;
            end
        end
    end

    // Address steering to the ROM plus range/alignment check on the granted address.
    always_comb begin
        sel_addr     = dbg_gnt ? dbg_addr : cpu_addr;
        sel_addr_ext = {1'b0, sel_addr};
        addr_err     = (sel_addr[1:0] != 2'b00)
                    || (sel_addr_ext < {1'b0, BASE_ADDR})
                    || (sel_addr_ext >= LIMIT);
        imem_addr    = sel_addr[13:2];
    end

    // Next-state for round-robin pointer, per-port response registers and contention counter.
    always_comb begin
        last_gnt_d     = last_gnt_q;
        cpu_rvalid_d   = cpu_gnt;
        cpu_rdata_d    = cpu_rdata_q;
        cpu_err_d      = cpu_err_q;
        dbg_rvalid_d   = dbg_gnt;
        dbg_rdata_d    = dbg_rdata_q;
        dbg_err_d      = dbg_err_q;
        conflict_cnt_d = conflict_cnt_q;

        if (cpu_gnt) begin
            last_gnt_d  = 1'b0;
            cpu_rdata_d = addr_err ? 32'h0 : imem_instr;
            cpu_err_d   = addr_err;
        end else if (dbg_gnt) begin
            last_gnt_d  = 1'b1;
            dbg_rdata_d = addr_err ? 32'h0 : imem_instr;
            dbg_err_d   = addr_err;
        end

        if (cpu_req && dbg_req && (conflict_cnt_q != {CNT_W{1'b1}})) begin
            conflict_cnt_d = conflict_cnt_q + CNT_W'(1);
        end
    end

    // State registers; reset leaves the pointer on debug so the CPU wins the first conflict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt_q     <= 1'b1;
            cpu_rvalid_q   <= 1'b0;
            cpu_rdata_q    <= 32'h0;
            cpu_err_q      <= 1'b0;
            dbg_rvalid_q   <= 1'b0;
            dbg_rdata_q    <= 32'h0;
            dbg_err_q      <= 1'b0;
            conflict_cnt_q <= '0;
        end else begin
            last_gnt_q     <= last_gnt_d;
            cpu_rvalid_q   <= cpu_rvalid_d;
            cpu_rdata_q    <= cpu_rdata_d;
            cpu_err_q      <= cpu_err_d;
            dbg_rvalid_q   <= dbg_rvalid_d;
            dbg_rdata_q    <= dbg_rdata_d;
            dbg_err_q      <= dbg_err_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign cpu_rvalid   = cpu_rvalid_q;
    assign cpu_rdata    = cpu_rdata_q;
    assign cpu_err      = cpu_err_q;
    assign dbg_rvalid   = dbg_rvalid_q;
    assign dbg_rdata    = dbg_rdata_q;
    assign dbg_err      = dbg_err_q;
    assign conflict_cnt = conflict_cnt_q;

endmodule
